// File: rtl/imem_responder_pkg.sv
// Shared constants for the instruction-memory responder: FSM state encoding,
// default sizing, error-cause bit positions and a small address helper.
package imem_responder_pkg;

  // Default sizing of the responder
  localparam int DEFAULT_MEM_DEPTH = 256;
  localparam int DEFAULT_LATENCY   = 2;

  // Latency counter width; holds LATENCY-1 for LATENCY up to 15
  localparam int CNT_W = 4;

  // FSM state encoding (kept as plain constants for legacy compatibility)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Error causes, one sticky bit each; errOut is their OR
  localparam int ERR_W          = 2;
  localparam int ERR_ADDR_RANGE = 0;  // request address above the store
  localparam int ERR_OVERRUN    = 1;  // request arrived with pending slot full

  typedef logic [ERR_W-1:0] errCause_t;

  // True when no address bit above the store index is set
  function automatic logic addrInRange(input logic [31:0] addr, input int idxW);
    return (addr >> idxW) == 32'd0;
  endfunction

endpackage

// File: rtl/imem_byte_ram.sv
// Byte-wide instruction store: one write port and one registered read port.
// A write and a read to the same index on the same edge return the new byte.
// Contents are never cleared, so there is deliberately no reset here.
module imem_byte_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          wrEn,
  input  logic [AW-1:0] wrAddr,
  input  logic [7:0]    wrData,
  input  logic          rdEn,
  input  logic [AW-1:0] rdAddr,
  output logic [7:0]    rdData
);

  logic [7:0] mem [DEPTH];

  // Write port plus registered, write-first read port
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
    if (rdEn) begin
      rdData <= (wrEn && (wrAddr == rdAddr)) ? wrData : mem[rdAddr];
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder. A two-phase request on triggerIn is
// synchronized, detected as a level change, and served by a small
// IDLE/READ/RESP machine that reads one byte from the preloadable store
// after a programmable latency and answers with a two-phase ackOut.
// One extra request may queue while busy; a further one is dropped and
// flagged on the sticky errOut, as is any out-of-range request address.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH,  // power of two, 16..4096
  parameter int LATENCY   = DEFAULT_LATENCY     // 1..15
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        triggerIn,
  input  logic [31:0] addrIn,
  output logic [7:0]  dataOut,
  output logic        readyOut,
  output logic        ackOut,
  input  logic        loadEn,
  input  logic [31:0] loadAddr,
  input  logic [7:0]  loadData,
  output logic        errOut
);

  localparam int             IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  // Request edge detection
  logic [1:0] syncReg;
  logic       edgeReg;
  logic       detect;

  // Control and datapath state
  logic [1:0]       stateReg;
  logic [CNT_W-1:0] cntReg;
  logic [IDX_W-1:0] idxReg;
  logic             oorReg;      // captured address was out of range
  logic             zeroOutReg;  // force dataOut to zero (reset / out of range)
  logic             readyReg;
  logic             ackReg;
  logic             pendingReg;
  errCause_t        errCauseReg;

  // Store interface
  logic       reqInRange;
  logic       loadInRange;
  logic       ramWrEn;
  logic       ramRdEn;
  logic [7:0] ramRdData;

  assign reqInRange  = addrInRange(addrIn, IDX_W);
  assign loadInRange = addrInRange(loadAddr, IDX_W);

  // Two-flop synchronizer on triggerIn plus a registered copy for edge detect
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      syncReg <= 2'b00;
      edgeReg <= 1'b0;
    end else begin
      syncReg <= {syncReg[0], triggerIn};
      edgeReg <= syncReg[1];
    end
  end

  // Every level change of the synchronized trigger is one request
  assign detect = syncReg[1] ^ edgeReg;

  // Out-of-range preloads are silently ignored
  assign ramWrEn = loadEn && loadInRange;

  // The store is read on the final READ cycle; skipped for out-of-range requests
  assign ramRdEn = (stateReg == ST_READ) && (cntReg == '0) && !oorReg;

  // Request FSM: capture, count down latency, respond; one-deep pending slot
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stateReg    <= ST_IDLE;
      cntReg      <= '0;
      idxReg      <= '0;
      oorReg      <= 1'b0;
      zeroOutReg  <= 1'b1;
      readyReg    <= 1'b1;
      ackReg      <= 1'b0;
      pendingReg  <= 1'b0;
      errCauseReg <= '0;
    end else begin
      case (stateReg)
        ST_IDLE: begin
          // A fresh detect or a queued request starts a read with the
          // address present now; if both occur, the new one stays queued.
          if (detect || pendingReg) begin
            idxReg     <= addrIn[IDX_W-1:0];
            oorReg     <= !reqInRange;
            readyReg   <= 1'b0;
            cntReg     <= CNT_INIT;
            stateReg   <= ST_READ;
            pendingReg <= detect && pendingReg;
            if (!reqInRange) begin
              errCauseReg[ERR_ADDR_RANGE] <= 1'b1;
            end
          end
        end

        ST_READ: begin
          if (cntReg == '0) begin
            // Store output register takes the byte on this same edge
            zeroOutReg <= oorReg;
            stateReg   <= ST_RESP;
          end else begin
            cntReg <= cntReg - 1'b1;
          end
          if (detect) begin
            if (pendingReg) begin
              errCauseReg[ERR_OVERRUN] <= 1'b1;
            end else begin
              pendingReg <= 1'b1;
            end
          end
        end

        ST_RESP: begin
          readyReg <= 1'b1;
          ackReg   <= ~ackReg;
          stateReg <= ST_IDLE;
          if (detect) begin
            if (pendingReg) begin
              errCauseReg[ERR_OVERRUN] <= 1'b1;
            end else begin
              pendingReg <= 1'b1;
            end
          end
        end

        default: begin
          stateReg <= ST_IDLE;
        end
      endcase
    end
  end

  imem_byte_ram #(
    .DEPTH (MEM_DEPTH),
    .AW    (IDX_W)
  ) uRam (
    .clk    (clk),
    .wrEn   (ramWrEn),
    .wrAddr (loadAddr[IDX_W-1:0]),
    .wrData (loadData),
    .rdEn   (ramRdEn),
    .rdAddr (idxReg),
    .rdData (ramRdData)
  );

  assign dataOut  = zeroOutReg ? 8'h00 : ramRdData;
  assign readyOut = readyReg;
  assign ackOut   = ackReg;
  assign errOut   = |errCauseReg;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder with a byte-array reference model.
module tb_imem_responder;

  localparam int DEPTH   = 256;
  localparam int LAT     = 2;
  localparam int EXP_LAT = 2 + 1 + LAT + 1;

  logic        clk = 1'b0;
  logic        rstN;
  logic        triggerIn;
  logic [31:0] addrIn;
  logic [7:0]  dataOut;
  logic        readyOut;
  logic        ackOut;
  logic        loadEn;
  logic [31:0] loadAddr;
  logic [7:0]  loadData;
  logic        errOut;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model of the byte store
  logic [7:0] refMem [DEPTH];

  always #5 clk = ~clk;

  imem_responder #(
    .MEM_DEPTH (DEPTH),
    .LATENCY   (LAT)
  ) dut (
    .clk       (clk),
    .rstN      (rstN),
    .triggerIn (triggerIn),
    .addrIn    (addrIn),
    .dataOut   (dataOut),
    .readyOut  (readyOut),
    .ackOut    (ackOut),
    .loadEn    (loadEn),
    .loadAddr  (loadAddr),
    .loadData  (loadData),
    .errOut    (errOut)
  );

  function automatic logic [7:0] refRead(input logic [31:0] a);
    if (a < DEPTH) return refMem[a[7:0]];
    return 8'h00;
  endfunction

  // One preload write; the model ignores out-of-range addresses
  task automatic load(input logic [31:0] a, input logic [7:0] d);
    @(negedge clk);
    loadEn = 1'b1; loadAddr = a; loadData = d;
    @(negedge clk);
    loadEn = 1'b0;
    if (a < DEPTH) refMem[a[7:0]] = d;
  endtask

  // Toggle the trigger and count rising edges until readyOut goes low then high
  task automatic request(input logic [31:0] a, output int lat);
    bit seenLow;
    @(negedge clk);
    addrIn = a; triggerIn = ~triggerIn;
    seenLow = 0; lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (readyOut !== 1'b1) seenLow = 1;
      else if (seenLow) begin lat = k; break; end
    end
  endtask

  task automatic resetPulse();
    @(negedge clk);
    rstN = 1'b0; triggerIn = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    rstN = 1'b0; triggerIn = 1'b0; addrIn = '0;
    loadEn = 1'b0; loadAddr = '0; loadData = '0;
    repeat (3) @(negedge clk);
    nChecks++; if (readyOut !== 1'b1) begin nFails++; $display("FAIL reset_ready got %b want 1", readyOut); end
    nChecks++; if (ackOut !== 1'b0) begin nFails++; $display("FAIL reset_ack got %b want 0", ackOut); end
    nChecks++; if (errOut !== 1'b0) begin nFails++; $display("FAIL reset_err got %b want 0", errOut); end
    nChecks++; if (dataOut !== 8'h00) begin nFails++; $display("FAIL reset_data got %h want 00", dataOut); end
    rstN = 1'b1;
    repeat (5) @(negedge clk);
    nChecks++; if (readyOut !== 1'b1) begin nFails++; $display("FAIL idle_ready got %b want 1", readyOut); end
    nChecks++; if (ackOut !== 1'b0) begin nFails++; $display("FAIL idle_ack got %b want 0", ackOut); end
    $display("reset: done");
  endtask

  task automatic test_preload();
    logic [7:0] bytesTab [4];
    int lat;
    bytesTab = '{8'h78, 8'h56, 8'h34, 8'h12};
    for (int i = 0; i < 4; i++) load(i, bytesTab[i]);
    for (int i = 0; i < 4; i++) begin
      request(i, lat);
      $display("preload read addr=%0d data=%h lat=%0d ack=%b", i, dataOut, lat, ackOut);
      nChecks++; if (dataOut !== bytesTab[i]) begin nFails++; $display("FAIL preload_data[%0d] got %h want %h", i, dataOut, bytesTab[i]); end
      nChecks++; if (lat != EXP_LAT) begin nFails++; $display("FAIL preload_lat[%0d] got %0d want %0d", i, lat, EXP_LAT); end
      nChecks++; if (ackOut !== triggerIn) begin nFails++; $display("FAIL preload_ack[%0d] got %b want %b", i, ackOut, triggerIn); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [7:0]  want;
    int lat;
    for (int i = 0; i < DEPTH; i++) load(i, 8'($urandom));
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      if (a < DEPTH) a = a | 32'h0000_0100;
      load(a, 8'($urandom));
    end
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a = $urandom_range(0, DEPTH - 1);
      want = refRead(a);
      request(a, lat);
      $display("random read addr=%0d data=%h lat=%0d", a, dataOut, lat);
      nChecks++; if (dataOut !== want) begin nFails++; $display("FAIL random_data addr=%0d got %h want %h", a, dataOut, want); end
      nChecks++; if (lat != EXP_LAT) begin nFails++; $display("FAIL random_lat got %0d want %0d", lat, EXP_LAT); end
      nChecks++; if (ackOut !== triggerIn) begin nFails++; $display("FAIL random_ack got %b want %b", ackOut, triggerIn); end
    end
    nChecks++; if (errOut !== 1'b0) begin nFails++; $display("FAIL random_err got %b want 0", errOut); end
  endtask

  // Request address 5 while loading a new byte there preEdges edges later
  task automatic collide(input logic [7:0] d, input int preEdges, input string tag);
    int lat;
    bit seenLow;
    @(negedge clk);
    addrIn = 32'd5; triggerIn = ~triggerIn;
    repeat (preEdges) @(negedge clk);
    loadEn = 1'b1; loadAddr = 32'd5; loadData = d;
    refMem[5] = d;
    @(negedge clk);
    loadEn = 1'b0;
    seenLow = (readyOut !== 1'b1);
    lat = -1;
    for (int k = preEdges + 2; k <= 40; k++) begin
      @(negedge clk);
      if (readyOut !== 1'b1) seenLow = 1;
      else if (seenLow) begin lat = k; break; end
    end
    $display("collision %s data=%h lat=%0d", tag, dataOut, lat);
    nChecks++; if (dataOut !== d) begin nFails++; $display("FAIL collide_%s_data got %h want %h", tag, dataOut, d); end
    nChecks++; if (lat != EXP_LAT) begin nFails++; $display("FAIL collide_%s_lat got %0d want %0d", tag, lat, EXP_LAT); end
  endtask

  task automatic test_collision();
    collide(8'hAA, 2, "capture");
    collide(8'hBB, 2 + LAT, "readedge");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    int doneAt;
    a = $urandom_range(0, DEPTH - 1);
    @(negedge clk);
    addrIn = a; triggerIn = ~triggerIn;
    doneAt = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 2) triggerIn = ~triggerIn;
      if (k >= 3 && readyOut === 1'b1 && ackOut === triggerIn) begin doneAt = k; break; end
    end
    $display("back_to_back addr=%0d data=%h done=%0d err=%b", a, dataOut, doneAt, errOut);
    nChecks++; if (doneAt != EXP_LAT + LAT + 2) begin nFails++; $display("FAIL b2b_done got %0d want %0d", doneAt, EXP_LAT + LAT + 2); end
    nChecks++; if (errOut !== 1'b0) begin nFails++; $display("FAIL b2b_err got %b want 0", errOut); end
    nChecks++; if (dataOut !== refRead(a)) begin nFails++; $display("FAIL b2b_data got %h want %h", dataOut, refRead(a)); end
  endtask

  task automatic test_out_of_range();
    int lat;
    request(32'h0000_0100, lat);
    $display("out_of_range data=%h err=%b lat=%0d ack=%b", dataOut, errOut, lat, ackOut);
    nChecks++; if (dataOut !== 8'h00) begin nFails++; $display("FAIL oor_data got %h want 00", dataOut); end
    nChecks++; if (errOut !== 1'b1) begin nFails++; $display("FAIL oor_err got %b want 1", errOut); end
    nChecks++; if (ackOut !== triggerIn) begin nFails++; $display("FAIL oor_ack got %b want %b", ackOut, triggerIn); end
    nChecks++; if (lat != EXP_LAT) begin nFails++; $display("FAIL oor_lat got %0d want %0d", lat, EXP_LAT); end
  endtask

  task automatic test_overrun();
    resetPulse();
    repeat (2) @(negedge clk);
    nChecks++; if (errOut !== 1'b0) begin nFails++; $display("FAIL overrun_errclr got %b want 0", errOut); end
    addrIn = 32'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      triggerIn = ~triggerIn;
    end
    repeat (25) @(negedge clk);
    $display("overrun ack=%b trig=%b err=%b data=%h", ackOut, triggerIn, errOut, dataOut);
    nChecks++; if (errOut !== 1'b1) begin nFails++; $display("FAIL overrun_err got %b want 1", errOut); end
    nChecks++; if (ackOut !== 1'b0) begin nFails++; $display("FAIL overrun_ack got %b want 0", ackOut); end
    nChecks++; if (readyOut !== 1'b1) begin nFails++; $display("FAIL overrun_ready got %b want 1", readyOut); end
    nChecks++; if (dataOut !== refRead(7)) begin nFails++; $display("FAIL overrun_data got %h want %h", dataOut, refRead(7)); end
  endtask

  task automatic test_reset_mid_read();
    int lat;
    resetPulse();
    repeat (2) @(negedge clk);
    @(negedge clk);
    addrIn = 32'd9; triggerIn = ~triggerIn;
    repeat (4) @(negedge clk);
    nChecks++; if (readyOut !== 1'b0) begin nFails++; $display("FAIL midread_busy got %b want 0", readyOut); end
    rstN = 1'b0; triggerIn = 1'b0;
    #1;
    nChecks++; if (readyOut !== 1'b1) begin nFails++; $display("FAIL midread_ready got %b want 1", readyOut); end
    nChecks++; if (ackOut !== 1'b0) begin nFails++; $display("FAIL midread_ack got %b want 0", ackOut); end
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    repeat (8) @(negedge clk);
    nChecks++; if (ackOut !== 1'b0) begin nFails++; $display("FAIL midread_noack got %b want 0", ackOut); end
    nChecks++; if (readyOut !== 1'b1) begin nFails++; $display("FAIL midread_idle got %b want 1", readyOut); end
    request(32'd9, lat);
    $display("after reset read addr=9 data=%h lat=%0d ack=%b", dataOut, lat, ackOut);
    nChecks++; if (dataOut !== refRead(9)) begin nFails++; $display("FAIL midread_data got %h want %h", dataOut, refRead(9)); end
    nChecks++; if (lat != EXP_LAT) begin nFails++; $display("FAIL midread_lat got %0d want %0d", lat, EXP_LAT); end
    nChecks++; if (ackOut !== 1'b1) begin nFails++; $display("FAIL midread_ack2 got %b want 1", ackOut); end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_random();
    test_collision();
    test_back_to_back();
    test_out_of_range();
    test_overrun();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
